// File: rtl/sram_fifo_ctrl.sv
// FIFO controller around a 256x32 1W/1R SRAM macro with a 3-entry prefetch output buffer.
// Optional registered almost_full/almost_empty flags are enabled by SRAM_FIFO_LEVEL_FLAGS_EN.
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int AF_THRESH  = 240,
  parameter int AE_THRESH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1,
  output logic [ADDR_WIDTH+1:0] level
`ifdef SRAM_FIFO_LEVEL_FLAGS_EN
  ,
  output logic                  almost_full,
  output logic                  almost_empty
`endif
);

  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int LVL_W = ADDR_WIDTH + 2;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAM_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE_C = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [CNT_W-1:0]      sram_cnt_r;
  logic [CNT_W-1:0]      sram_cnt_next_s;
  logic                  inflight_r;
  logic [DATA_WIDTH-1:0] obuf_r [3];
  logic [DATA_WIDTH-1:0] obuf_next_s [3];
  logic [1:0]            obuf_cnt_r;
  logic [1:0]            obuf_cnt_next_s;
  logic [1:0]            cap_idx_s;
  logic                  in_ready_r;
  logic [LVL_W-1:0]      level_r;
  logic [LVL_W-1:0]      level_next_s;
  logic                  push_s;
  logic                  issue_s;
  logic                  pop_s;

  // Issue only on registered state, so a word written this cycle is never read this cycle.
  assign push_s  = in_valid & in_ready_r;
  assign issue_s = (sram_cnt_r != {CNT_W{1'b0}}) &
                   (({1'b0, obuf_cnt_r} + {2'b00, inflight_r}) < 3'd3);
  assign pop_s   = (obuf_cnt_r != 2'd0) & out_ready;

  assign sram_csb0  = ~push_s;
  assign sram_addr0 = wr_ptr_r;
  assign sram_din0  = in_data;
  assign sram_csb1  = ~issue_s;
  assign sram_addr1 = rd_ptr_r;

  assign in_ready  = in_ready_r;
  assign out_valid = (obuf_cnt_r != 2'd0);
  assign out_data  = obuf_r[0];
  assign level     = level_r;

  // Next-state for counts and the output buffer (shift on pop, then capture at the tail).
  always_comb begin
    if (push_s && !issue_s) begin
      sram_cnt_next_s = sram_cnt_r + CNT_ONE_C;
    end else if (!push_s && issue_s) begin
      sram_cnt_next_s = sram_cnt_r - CNT_ONE_C;
    end else begin
      sram_cnt_next_s = sram_cnt_r;
    end

    if (inflight_r && !pop_s) begin
      obuf_cnt_next_s = obuf_cnt_r + 2'd1;
    end else if (!inflight_r && pop_s) begin
      obuf_cnt_next_s = obuf_cnt_r - 2'd1;
    end else begin
      obuf_cnt_next_s = obuf_cnt_r;
    end

    cap_idx_s = obuf_cnt_r - {1'b0, pop_s};

    if (pop_s) begin
      obuf_next_s[0] = obuf_r[1];
      obuf_next_s[1] = obuf_r[2];
      obuf_next_s[2] = obuf_r[2];
    end else begin
      obuf_next_s[0] = obuf_r[0];
      obuf_next_s[1] = obuf_r[1];
      obuf_next_s[2] = obuf_r[2];
    end

    if (inflight_r) begin
      case (cap_idx_s)
        2'd0:    obuf_next_s[0] = sram_dout1;
        2'd1:    obuf_next_s[1] = sram_dout1;
        2'd2:    obuf_next_s[2] = sram_dout1;
        default: ;
      endcase
    end else begin
      cap_idx_s = cap_idx_s;
    end

    level_next_s = LVL_W'(sram_cnt_next_s) + LVL_W'(issue_s) + LVL_W'(obuf_cnt_next_s);
  end

  // Controller state; reset discards everything including an outstanding read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r   <= {ADDR_WIDTH{1'b0}};
      sram_cnt_r <= {CNT_W{1'b0}};
      inflight_r <= 1'b0;
      obuf_cnt_r <= 2'd0;
      in_ready_r <= 1'b0;
      level_r    <= {LVL_W{1'b0}};
      for (int i = 0; i < 3; i++) begin
        obuf_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (issue_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      sram_cnt_r <= sram_cnt_next_s;
      inflight_r <= issue_s;
      obuf_cnt_r <= obuf_cnt_next_s;
      in_ready_r <= (sram_cnt_next_s < DEPTH_C);
      level_r    <= level_next_s;
      for (int i = 0; i < 3; i++) begin
        obuf_r[i] <= obuf_next_s[i];
      end
    end
  end

`ifdef SRAM_FIFO_LEVEL_FLAGS_EN
  localparam logic [LVL_W-1:0] AF_C = LVL_W'(AF_THRESH);
  localparam logic [LVL_W-1:0] AE_C = LVL_W'(AE_THRESH);

  // Level flags track level_next so they change together with level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (level_next_s >= AF_C);
      almost_empty <= (level_next_s <= AE_C);
    end
  end
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural 1W/1R SRAM model and a word scoreboard.
module tb_sram_fifo_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        sram_csb0;
  logic [7:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic        sram_csb1;
  logic [7:0]  sram_addr1;
  logic [31:0] sram_dout1;
  logic [9:0]  level;
`ifdef SRAM_FIFO_LEVEL_FLAGS_EN
  logic        almost_full;
  logic        almost_empty;
`endif

  sram_fifo_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .sram_csb0  (sram_csb0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_csb1  (sram_csb1),
    .sram_addr1 (sram_addr1),
    .sram_dout1 (sram_dout1),
    .level      (level)
`ifdef SRAM_FIFO_LEVEL_FLAGS_EN
    ,
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Macro model: registered read data, one cycle after the read select.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (!sram_csb0) mem[sram_addr0] <= sram_din0;
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
  end

  int n_vec = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] src_q[$];

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        e_irdy;
    logic        e_ov;
    logic        chk_d;
    logic [31:0] e_od;
    logic [9:0]  e_lvl;
    logic        e_csb0;
    logic [7:0]  e_a0;
    logic        e_csb1;
    logic [7:0]  e_a1;
  } vec_t;

  vec_t vt[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_flags(input int lvl);
`ifdef SRAM_FIFO_LEVEL_FLAGS_EN
    check("almost_full", {63'd0, almost_full}, {63'd0, (lvl >= 240)});
    check("almost_empty", {63'd0, almost_empty}, {63'd0, (lvl <= 4)});
`else
    n_vec = n_vec + 0 * lvl;
`endif
  endtask

  // Drives src_q into the FIFO and checks every output word against exp_q.
  task automatic run_traffic(input bit rnd_out, input int budget, input string tag);
    int cyc = 0;
    int gaps = 0;
    bit started = 1'b0;
    bit stall_prev = 1'b0;
    logic [31:0] stall_data = 32'd0;
    while ((src_q.size() != 0 || exp_q.size() != 0) && cyc < budget) begin
      in_valid  = (src_q.size() != 0);
      in_data   = (src_q.size() != 0) ? src_q[0] : 32'd0;
      out_ready = rnd_out ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stall_prev) begin
        check({tag, "_stall_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_stall_data"}, {32'd0, out_data}, {32'd0, stall_data});
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(src_q.pop_front());
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_word"}, {32'd0, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          check({tag, "_data"}, {32'd0, out_data}, {32'd0, exp_q.pop_front()});
        end
        started = 1'b1;
      end else if (!out_valid && started && exp_q.size() != 0) begin
        gaps++;
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check({tag, "_done_in_budget"}, {63'd0, (cyc < budget)}, 64'd1);
    if (!rnd_out) check({tag, "_gaps"}, 64'(gaps), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    bit got;

    vt[0]  = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0,        10'd0, 1'b0, 8'd0, 1'b1, 8'd0};
    vt[1]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        10'd1, 1'b1, 8'd1, 1'b0, 8'd0};
    vt[2]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        10'd1, 1'b1, 8'd1, 1'b1, 8'd1};
    vt[3]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 10'd1, 1'b1, 8'd1, 1'b1, 8'd1};
    vt[4]  = '{1'b1, 32'h11111111, 1'b1, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 10'd1, 1'b0, 8'd1, 1'b1, 8'd1};
    vt[5]  = '{1'b1, 32'h22222222, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        10'd1, 1'b0, 8'd2, 1'b0, 8'd1};
    vt[6]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        10'd2, 1'b1, 8'd3, 1'b0, 8'd2};
    vt[7]  = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 1'b1, 32'h11111111, 10'd2, 1'b1, 8'd3, 1'b1, 8'd3};
    vt[8]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 32'h11111111, 10'd2, 1'b1, 8'd3, 1'b1, 8'd3};
    vt[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 1'b1, 32'h22222222, 10'd1, 1'b1, 8'd3, 1'b1, 8'd3};
    vt[10] = '{1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        10'd0, 1'b1, 8'd3, 1'b1, 8'd3};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_csb0", {63'd0, sram_csb0}, 64'd1);
    check("rst_csb1", {63'd0, sram_csb1}, 64'd1);
    check("rst_addr0", 64'(sram_addr0), 64'd0);
    check("rst_addr1", 64'(sram_addr1), 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check_flags(0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release_in_ready_low", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    #1;
    check("release_in_ready_high", {63'd0, in_ready}, 64'd1);
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      in_valid = vt[i].iv; in_data = vt[i].id; out_ready = vt[i].ordy;
      #1;
      check($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, {63'd0, vt[i].e_irdy});
      check($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vt[i].e_ov});
      if (vt[i].chk_d) check($sformatf("v%0d_out_data", i), {32'd0, out_data}, {32'd0, vt[i].e_od});
      check($sformatf("v%0d_level", i), 64'(level), 64'(vt[i].e_lvl));
      check($sformatf("v%0d_csb0", i), {63'd0, sram_csb0}, {63'd0, vt[i].e_csb0});
      check($sformatf("v%0d_addr0", i), 64'(sram_addr0), 64'(vt[i].e_a0));
      check($sformatf("v%0d_csb1", i), {63'd0, sram_csb1}, {63'd0, vt[i].e_csb1});
      check($sformatf("v%0d_addr1", i), 64'(sram_addr1), 64'(vt[i].e_a1));
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;

    for (int i = 0; i < 1000; i++) src_q.push_back(32'(i));
    run_traffic(1'b0, 1100, "stream");

    for (int i = 0; i < 300; i++) src_q.push_back($urandom);
    run_traffic(1'b1, 3000, "bkpr");

    // Fill with the consumer stalled: level tracks accepted words exactly.
    @(negedge clk);
    acc = 0;
    for (int c = 0; c < 300; c++) begin
      in_valid = 1'b1; in_data = 32'hF000_0000 + 32'(acc); out_ready = 1'b0;
      #1;
      check("fill_level", 64'(level), 64'(acc));
      check_flags(acc);
      if (in_ready) begin
        exp_q.push_back(in_data);
        acc++;
      end
      @(negedge clk);
    end
    #1;
    check("fill_accepted", 64'(acc), 64'd259);
    check("fill_in_ready", {63'd0, in_ready}, 64'd0);
    check("fill_level_full", 64'(level), 64'd259);
    check("fill_out_valid", {63'd0, out_valid}, 64'd1);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("fill_pop_data", {32'd0, out_data}, {32'd0, exp_q.pop_front()});
    @(negedge clk);
    out_ready = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = !got;
      #1;
      if (!got && in_ready) begin
        exp_q.push_back(in_data);
        got = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("refill_260th_accepted", {63'd0, got}, 64'd1);
    run_traffic(1'b0, 400, "drain");

    // Load 100 words, pop one so a read goes in flight, then reset mid-operation.
    acc = 0;
    for (int c = 0; c < 120 && acc < 100; c++) begin
      in_valid = 1'b1; in_data = 32'hC000_0000 + 32'(acc); out_ready = 1'b0;
      #1;
      if (in_ready) acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    #1;
    check("prereset_level", 64'(level), 64'd99);
    #1;
    rst_n = 1'b0;
    #1;
    check("areset_out_valid", {63'd0, out_valid}, 64'd0);
    check("areset_level", 64'(level), 64'd0);
    check("areset_in_ready", {63'd0, in_ready}, 64'd0);
    check("areset_csb1", {63'd0, sram_csb1}, 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    src_q.push_back(32'hA5A5A5A5);
    src_q.push_back(32'h5A5A5A5A);
    run_traffic(1'b0, 20, "post_reset");
    #1;
    check("post_reset_level", 64'(level), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
